byte_group_tx: RTL and testbench

Transmit-side counterpart of the four-beat byte accumulator. Accepts one 32-bit word per valid/ready handshake, serializes it onto an 8-bit stream as four beats (least significant byte first), and marks the final beat. Also emits the 10-bit sum of the four bytes, so a downstream accumulator's result can be checked against it. Sits between the word-wide source and the byte-stream accumulation path.

---
 rtl/byte_group_pkg.sv | 14 +
 rtl/group_sum.sv | 24 ++
 rtl/byte_group_tx.sv | 114 +++++++++++
 tb/tb_byte_group_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/byte_group_pkg.sv
// Shared constants and types for the byte-group transmit/accumulate path.
package byte_group_pkg;

    localparam int DATA_W = 8;
    localparam int BEATS  = 4;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int SUM_W  = DATA_W + CNT_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/group_sum.sv
// Combinational adder: zero-extended sum of BEATS lanes of DATA_W bits each.
// Sized so that the all-ones input cannot overflow SUM_W.
module group_sum #(
    parameter int DATA_W = 8,
    parameter int BEATS  = 4,
    parameter int SUM_W  = 10
) (
    input  logic [DATA_W*BEATS-1:0] lanes,
    output logic [SUM_W-1:0]        sum
);

    logic [SUM_W-1:0] acc_s;

    // Add every lane after zero-extending it to the result width.
    always_comb begin
        acc_s = '0;
        for (int i = 0; i < BEATS; i++) begin
            acc_s = acc_s + SUM_W'(lanes[i*DATA_W +: DATA_W]);
        end
    end

    assign sum = acc_s;

endmodule

// File: rtl/byte_group_tx.sv
// Serializes 32-bit words into four byte beats (LSB first), flags the final
// beat, and reports the byte sum of each completed word.
module byte_group_tx
    import byte_group_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W*BEATS-1:0] word_in,
    input  logic                    word_valid,
    output logic                    word_ready,
    output logic [DATA_W-1:0]       byte_out,
    output logic                    byte_valid,
    input  logic                    byte_ready,
    output logic                    byte_last,
    output logic [SUM_W-1:0]        sum_out,
    output logic                    sum_valid
);

    state_t                    state_r;
    logic [DATA_W*BEATS-1:0]   shift_r;
    logic [CNT_W-1:0]          cnt_r;
    logic [SUM_W-1:0]          pend_sum_r;
    logic [SUM_W-1:0]          sum_out_r;
    logic                      byte_valid_r;
    logic                      byte_last_r;
    logic                      sum_valid_r;

    logic [SUM_W-1:0]          word_sum_s;
    logic                      word_ready_s;
    logic                      load_s;
    logic                      xfer_s;
    logic                      last_xfer_s;

    // The byte sum is computed on the incoming word so it can be captured at load.
    group_sum #(
        .DATA_W (DATA_W),
        .BEATS  (BEATS),
        .SUM_W  (SUM_W)
    ) u_group_sum (
        .lanes (word_in),
        .sum   (word_sum_s)
    );

    // Ready when idle, or when the final beat leaves this cycle (no bubble).
    always_comb begin
        word_ready_s = 1'b0;
        case (state_r)
            IDLE:    word_ready_s = 1'b1;
            SEND:    word_ready_s = byte_last_r && byte_ready;
            default: word_ready_s = 1'b0;
        endcase
    end

    assign load_s      = word_valid && word_ready_s;
    assign xfer_s      = byte_valid_r && byte_ready;
    assign last_xfer_s = xfer_s && byte_last_r;

    // FSM, shift register, beat counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            shift_r      <= '0;
            cnt_r        <= '0;
            pend_sum_r   <= '0;
            sum_out_r    <= '0;
            byte_valid_r <= 1'b0;
            byte_last_r  <= 1'b0;
            sum_valid_r  <= 1'b0;
        end else begin
            // The sum of the outgoing word is published as its last beat leaves;
            // pend_sum_r may be overwritten by a new load in the same cycle.
            sum_valid_r <= last_xfer_s;
            if (last_xfer_s) begin
                sum_out_r <= pend_sum_r;
            end else begin
                sum_out_r <= sum_out_r;
            end

            if (load_s) begin
                state_r      <= SEND;
                shift_r      <= word_in;
                pend_sum_r   <= word_sum_s;
                cnt_r        <= '0;
                byte_valid_r <= 1'b1;
                byte_last_r  <= 1'b0;
            end else if (last_xfer_s) begin
                state_r      <= IDLE;
                shift_r      <= '0;
                cnt_r        <= '0;
                byte_valid_r <= 1'b0;
                byte_last_r  <= 1'b0;
            end else if (xfer_s) begin
                shift_r      <= shift_r >> DATA_W;
                cnt_r        <= cnt_r + CNT_W'(1);
                // Next beat is the final one when the counter is about to reach BEATS-1.
                byte_last_r  <= (cnt_r == CNT_W'(BEATS - 2));
            end else begin
                state_r      <= state_r;
                shift_r      <= shift_r;
                cnt_r        <= cnt_r;
                byte_valid_r <= byte_valid_r;
                byte_last_r  <= byte_last_r;
            end
        end
    end

    assign word_ready = word_ready_s;
    assign byte_out   = shift_r[DATA_W-1:0];
    assign byte_valid = byte_valid_r;
    assign byte_last  = byte_last_r;
    assign sum_out    = sum_out_r;
    assign sum_valid  = sum_valid_r;

endmodule

// File: tb/tb_byte_group_tx.sv
// Scoreboard bench for byte_group_tx: accepted words are expanded into expected
// beats and sums by a behavioural model; a monitor pops and compares them.
module tb_byte_group_tx;
    import byte_group_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_last;
    logic [9:0]  sum_out;
    logic        sum_valid;

    int n_cmp = 0;
    int n_err = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: driven by the test

    logic [8:0] bq[$];  // {last, byte}
    logic [9:0] sq[$];

    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte  = 8'h00;
    logic       prev_last  = 1'b0;

    byte_group_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_last  (byte_last),
        .sum_out    (sum_out),
        .sum_valid  (sum_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold a word on the input until it is taken (bounded).
    task automatic offer(input logic [31:0] w);
        bit acc = 1'b0;
        word_in    = w;
        word_valid = 1'b1;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            if (word_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        word_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL offer_timeout: actual=not_accepted required=accepted word=%0h", w);
        end
    endtask

    // Backpressure generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) byte_ready = ($urandom_range(0, 3) != 0);
            else if (rdy_mode == 0) byte_ready = 1'b1;
        end
    end

    // Monitor / scoreboard: everything sampled mid-cycle, handshakes resolve at the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                chk("word_ready_rule", word_ready, !byte_valid || (byte_last && byte_ready));
                if (prev_stall) begin
                    chk("hold_valid", byte_valid, 1'b1);
                    chk("hold_byte", byte_out, prev_byte);
                    chk("hold_last", byte_last, prev_last);
                end
                if (byte_valid && byte_ready) begin
                    if (bq.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_beat: actual=%0h required=none", byte_out);
                    end else begin
                        logic [8:0] e;
                        e = bq.pop_front();
                        chk("byte_out", byte_out, e[7:0]);
                        chk("byte_last", byte_last, e[8]);
                    end
                end
                if (sum_valid) begin
                    if (sq.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_sum: actual=%0h required=none", sum_out);
                    end else begin
                        chk("sum_out", sum_out, sq.pop_front());
                    end
                end
                if (word_valid && word_ready) begin
                    int s;
                    s = 0;
                    for (int i = 0; i < 4; i++) begin
                        bq.push_back({(i == 3), word_in[8*i +: 8]});
                        s = s + int'(word_in[8*i +: 8]);
                    end
                    sq.push_back(10'(s));
                end
                prev_stall = byte_valid && !byte_ready;
                prev_byte  = byte_out;
                prev_last  = byte_last;
            end
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_byte_out"}, byte_out, 8'h00);
        chk({tag, "_byte_valid"}, byte_valid, 1'b0);
        chk({tag, "_byte_last"}, byte_last, 1'b0);
        chk({tag, "_sum_out"}, sum_out, 10'd0);
        chk({tag, "_sum_valid"}, sum_valid, 1'b0);
        chk({tag, "_word_ready"}, word_ready, 1'b1);
    endtask

    initial begin
        rst_n      = 1'b0;
        word_valid = 1'b0;
        word_in    = 32'h0;
        byte_ready = 1'b1;
        idle(2);
        @(negedge clk);
        chk_zero_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Single word and maximum sum.
        offer(32'h04030201);
        idle(6);
        offer(32'hFFFFFFFF);
        idle(6);

        // Back-to-back words: eight beats without a gap.
        offer(32'h11223344);
        fork
            offer(32'hA0B0C0D0);
            begin
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    chk("no_gap", byte_valid, 1'b1);
                end
            end
        join
        idle(6);

        // Backpressure during beat 1.
        rdy_mode   = 2;
        byte_ready = 1'b1;
        offer(32'h0000FF80);
        idle(1);
        byte_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_byte", byte_out, 8'hFF);
            chk("bp_last", byte_last, 1'b0);
            chk("bp_word_ready", word_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        byte_ready = 1'b1;
        rdy_mode   = 0;
        idle(6);

        // Reset in the middle of a word.
        offer(32'h55667788);
        idle(1);
        rst_n = 1'b0;
        bq.delete();
        sq.delete();
        #1;
        chk_zero_outputs("midreset");
        idle(1);
        rst_n = 1'b1;
        offer(32'h01010101);
        idle(6);

        // Idle source.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_byte_valid", byte_valid, 1'b0);
            chk("idle_sum_valid", sum_valid, 1'b0);
            chk("idle_word_ready", word_ready, 1'b1);
            @(posedge clk);
            #1;
        end

        // Random words, random gaps, random backpressure.
        rdy_mode = 1;
        for (int n = 0; n < 40; n++) begin
            offer($urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        rdy_mode = 0;
        for (int k = 0; k < 200 && bq.size() != 0; k++) idle(1);
        idle(3);
        chk("drain_bytes", bq.size(), 0);
        chk("drain_sums", sq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
